// File: rtl/alu_result_register.sv
// Registered output stage for the lab ALU: synchronized go strobe, capture/shift/rotate/undo ops.
// Define ALU_REG_HIST_EN to build the history LIFO with undo; otherwise mode 11 is a clear op.
module alu_result_register #(
  parameter int WIDTH      = 8,
  parameter int HIST_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       b_feedback,
  output logic             carry,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [2:0]       history_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_CAPTURE = 2'd0;
  localparam logic [1:0] OP_SHL     = 2'd1;
  localparam logic [1:0] OP_ROR     = 2'd2;

  state_t           state, state_nxt;
  logic             go_s1, go_s2, go_s3, go_pulse;
  logic [1:0]       op_mode_p0;
  logic [WIDTH-1:0] op_data_p0;
  logic [WIDTH-1:0] result_nxt;
  logic             carry_nxt;
  logic             op_err;
  logic             do_push, do_pop;

  assign go_pulse   = go_s2 & ~go_s3;
  assign busy       = (state != IDLE);
  assign b_feedback = result[3:0];

`ifdef ALU_REG_HIST_EN
  localparam int         IDX_W   = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(HIST_DEPTH);

  logic [WIDTH-1:0] hist_mem [HIST_DEPTH];
  logic [2:0]       hist_cnt;
  logic [IDX_W-1:0] top_idx, wr_idx;
  logic [WIDTH-1:0] hist_top;

  assign top_idx       = IDX_W'(hist_cnt - 3'd1);
  assign wr_idx        = IDX_W'(hist_cnt);
  assign hist_top      = hist_mem[top_idx];
  assign history_count = hist_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_cnt <= 3'd0;
    end else if (do_pop) begin
      hist_cnt <= hist_cnt - 3'd1;
    end else if (do_push && (hist_cnt < DEPTH_C)) begin
      hist_cnt <= hist_cnt + 3'd1;
    end
  end

  // When full, the oldest entry (index 0) falls off and the new value lands on top.
  always_ff @(posedge clock) begin
    if (do_push) begin
      if (hist_cnt < DEPTH_C) begin
        hist_mem[wr_idx] <= result;
      end else begin
        for (int i = 0; i < HIST_DEPTH - 1; i++) begin
          hist_mem[i] <= hist_mem[i+1];
        end
        hist_mem[HIST_DEPTH-1] <= result;
      end
    end
  end
`else
  logic unused_hist;

  assign history_count = 3'd0;
  assign unused_hist   = ^{do_push, do_pop};
`endif

  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    carry_nxt  = carry;
    op_err     = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (go_pulse) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = DONE;
        case (op_mode_p0)
          OP_CAPTURE: begin
            do_push    = 1'b1;
            result_nxt = op_data_p0;
            carry_nxt  = 1'b0;
          end
          OP_SHL: begin
            do_push    = 1'b1;
            result_nxt = {result[WIDTH-2:0], 1'b0};
            carry_nxt  = result[WIDTH-1];
          end
          OP_ROR: begin
            do_push    = 1'b1;
            result_nxt = {result[0], result[WIDTH-1:1]};
          end
          default: begin
`ifdef ALU_REG_HIST_EN
            if (hist_cnt != 3'd0) begin
              do_pop     = 1'b1;
              result_nxt = hist_top;
              carry_nxt  = 1'b0;
            end else begin
              op_err = 1'b1;
            end
`else
            result_nxt = '0;
            carry_nxt  = 1'b0;
`endif
          end
        endcase
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Synchronizer resets high so a go held through reset needs a release and re-press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      go_s1  <= 1'b1;
      go_s2  <= 1'b1;
      go_s3  <= 1'b1;
      state  <= IDLE;
      result <= '0;
      carry  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      go_s1  <= go;
      go_s2  <= go_s1;
      go_s3  <= go_s2;
      state  <= state_nxt;
      result <= result_nxt;
      carry  <= carry_nxt;
      done   <= (state == EXEC);
      err    <= op_err;
    end
  end

  // Op latch stage: freezes mode and ALU output at the go edge.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && go_pulse) begin
      op_mode_p0 <= mode;
      op_data_p0 <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_result_register.sv
// Self-checking bench for alu_result_register against a queue-based reference model.
module tb_alu_result_register;
  localparam int WIDTH = 8;
  localparam int HIST_DEPTH = 4;
`ifdef ALU_REG_HIST_EN
  localparam int MODEL_DEPTH = HIST_DEPTH;
`else
  localparam int MODEL_DEPTH = 0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             go;
  logic [1:0]       mode;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result;
  logic [3:0]       b_feedback;
  logic             carry, done, err, busy;
  logic [2:0]       history_count;

  alu_result_register #(.WIDTH(WIDTH), .HIST_DEPTH(HIST_DEPTH)) dut (
    .clock(clock), .reset(reset), .go(go), .mode(mode), .alu_result(alu_result),
    .result(result), .b_feedback(b_feedback), .carry(carry), .done(done),
    .err(err), .busy(busy), .history_count(history_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int m_result;
  int m_carry;
  int hist_q[$];

  typedef struct {
    int         done_cnt;
    int         done_at;
    int         err_cnt;
    logic [7:0] r;
    logic       c;
    logic       e;
    logic [2:0] hc;
    logic [3:0] bfb;
    logic       busy_x;
  } obs_t;

  task automatic model_clear();
    m_result = 0;
    m_carry  = 0;
    hist_q.delete();
  endtask

  task automatic model_push(input int v);
    hist_q.push_back(v);
    if (hist_q.size() > MODEL_DEPTH) void'(hist_q.pop_front());
  endtask

  task automatic model_apply(input logic [1:0] m, input logic [7:0] d,
                             output int er, output int ec, output int ee, output int ehc);
    ee = 0;
    case (m)
      2'd0: begin model_push(m_result); m_result = d; m_carry = 0; end
      2'd1: begin model_push(m_result); m_carry = m_result / 128; m_result = (m_result * 2) % 256; end
      2'd2: begin model_push(m_result); m_result = (m_result / 2) + (m_result % 2) * 128; end
      default: begin
`ifdef ALU_REG_HIST_EN
        if (hist_q.size() > 0) begin m_result = hist_q.pop_back(); m_carry = 0; end
        else ee = 1;
`else
        m_result = 0; m_carry = 0;
`endif
      end
    endcase
    er = m_result; ec = m_carry; ehc = hist_q.size();
  endtask

  // Drives one go press; go is high for exactly one sampling edge (edge k).
  task automatic run_op(input logic [1:0] m, input logic [7:0] d, input bit toggle,
                        input bit retrig, output obs_t o);
    o.done_cnt = 0; o.done_at = 0; o.err_cnt = 0; o.r = '0; o.c = 0; o.e = 0;
    o.hc = '0; o.bfb = '0; o.busy_x = 0;
    @(negedge clock); mode = m; alu_result = d; go = 1'b1;
    @(posedge clock);
    @(negedge clock); go = 1'b0;
    @(posedge clock);
    @(negedge clock); if (retrig) go = 1'b1;
    @(posedge clock);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (i == 1) o.busy_x = busy;
      if (err) o.err_cnt++;
      if (done) begin
        o.done_cnt++;
        if (o.done_cnt == 1) begin
          o.done_at = i; o.r = result; o.c = carry; o.e = err;
          o.hc = history_count; o.bfb = b_feedback;
        end
      end
      if (toggle) alu_result = 8'($urandom);
      if (i == 3) go = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    obs_t o;
    int er, ec, ee, ehc, dcnt;
    reset = 1'b1; go = 1'b1; mode = 2'd0; alu_result = 8'hFF;
    repeat (3) @(negedge clock);
    tests++; if ({result, carry, done, err, busy, history_count} !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {result, carry, done, err, busy, history_count}); end
    reset = 1'b0; model_clear();
    dcnt = 0;
    repeat (8) begin @(negedge clock); if (done) dcnt++; end
    tests++; if (dcnt !== 0) begin fails++; $display("FAIL reset_go_held_done: got %0d want 0", dcnt); end
    tests++; if (result !== 8'h00 || busy !== 1'b0) begin fails++; $display("FAIL reset_go_held_state: result %h busy %b want 00 0", result, busy); end
    go = 1'b0;
    repeat (3) @(negedge clock);
    run_op(2'd0, 8'h3C, 0, 0, o);
    model_apply(2'd0, 8'h3C, er, ec, ee, ehc);
    tests++; if (o.done_cnt !== 1) begin fails++; $display("FAIL reset_repress_done: got %0d want 1", o.done_cnt); end
    tests++; if (o.r !== 8'(er)) begin fails++; $display("FAIL reset_repress_result: got %h want %h", o.r, 8'(er)); end
  endtask

  task automatic test_capture();
    obs_t o;
    int er, ec, ee, ehc;
    run_op(2'd0, 8'h0A, 0, 0, o);
    model_apply(2'd0, 8'h0A, er, ec, ee, ehc);
    tests++; if (o.done_cnt !== 1 || o.done_at !== 2) begin fails++; $display("FAIL cap_done_timing: count %0d at %0d want 1 at 2", o.done_cnt, o.done_at); end
    tests++; if (o.r !== 8'h0A) begin fails++; $display("FAIL cap_result: got %h want 0a", o.r); end
    tests++; if (o.bfb !== 4'hA) begin fails++; $display("FAIL cap_b_feedback: got %h want a", o.bfb); end
    tests++; if (o.hc !== 3'(ehc)) begin fails++; $display("FAIL cap_history_count: got %0d want %0d", o.hc, ehc); end
    tests++; if (o.busy_x !== 1'b1) begin fails++; $display("FAIL cap_busy_exec: got %b want 1", o.busy_x); end
    tests++; if (o.c !== 1'b0) begin fails++; $display("FAIL cap_carry: got %b want 0", o.c); end
  endtask

  task automatic test_shift_rotate();
    obs_t o;
    int er, ec, ee, ehc;
    run_op(2'd0, 8'h81, 0, 0, o);
    model_apply(2'd0, 8'h81, er, ec, ee, ehc);
    run_op(2'd1, 8'h00, 0, 0, o);
    model_apply(2'd1, 8'h00, er, ec, ee, ehc);
    tests++; if (o.r !== 8'h02 || o.c !== 1'b1) begin fails++; $display("FAIL shl_result: got %h/%b want 02/1", o.r, o.c); end
    tests++; if (o.hc !== 3'(ehc)) begin fails++; $display("FAIL shl_history_count: got %0d want %0d", o.hc, ehc); end
    run_op(2'd2, 8'h00, 0, 0, o);
    model_apply(2'd2, 8'h00, er, ec, ee, ehc);
    tests++; if (o.r !== 8'h01 || o.c !== 1'b1) begin fails++; $display("FAIL ror_result: got %h/%b want 01/1", o.r, o.c); end
    tests++; if (o.hc !== 3'(ehc)) begin fails++; $display("FAIL ror_history_count: got %0d want %0d", o.hc, ehc); end
  endtask

  task automatic test_history();
    obs_t o;
    int er, ec, ee, ehc;
    apply_reset();
    for (int v = 1; v <= 5; v++) begin
      run_op(2'd0, 8'(v), 0, 0, o);
      model_apply(2'd0, 8'(v), er, ec, ee, ehc);
    end
    tests++; if (o.hc !== 3'(ehc)) begin fails++; $display("FAIL hist_full_count: got %0d want %0d", o.hc, ehc); end
    for (int n = 0; n < 5; n++) begin
      run_op(2'd3, 8'h00, 0, 0, o);
      model_apply(2'd3, 8'h00, er, ec, ee, ehc);
      tests++; if (o.r !== 8'(er) || o.c !== 1'(ec)) begin fails++; $display("FAIL undo_result #%0d: got %h/%b want %h/%b", n, o.r, o.c, 8'(er), 1'(ec)); end
      tests++; if (o.e !== 1'(ee) || o.err_cnt !== ee) begin fails++; $display("FAIL undo_err #%0d: got %b (pulses %0d) want %0d", n, o.e, o.err_cnt, ee); end
      tests++; if (o.hc !== 3'(ehc) || o.done_cnt !== 1) begin fails++; $display("FAIL undo_count #%0d: got hc %0d done %0d want %0d 1", n, o.hc, o.done_cnt, ehc); end
    end
  endtask

  task automatic test_sample_hold();
    obs_t o;
    int er, ec, ee, ehc;
    run_op(2'd0, 8'h5A, 1, 1, o);
    model_apply(2'd0, 8'h5A, er, ec, ee, ehc);
    tests++; if (o.r !== 8'h5A) begin fails++; $display("FAIL hold_result: got %h want 5a", o.r); end
    tests++; if (o.done_cnt !== 1) begin fails++; $display("FAIL retrigger_done_count: got %0d want 1", o.done_cnt); end
  endtask

  task automatic test_random();
    obs_t o;
    int er, ec, ee, ehc;
    logic [1:0] m;
    logic [7:0] d;
    for (int n = 0; n < 40; n++) begin
      m = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      run_op(m, d, 1'($urandom), 1'($urandom), o);
      model_apply(m, d, er, ec, ee, ehc);
      tests++; if (o.done_cnt !== 1 || o.done_at !== 2) begin fails++; $display("FAIL rand_done op%0d: count %0d at %0d want 1 at 2", n, o.done_cnt, o.done_at); end
      tests++; if (o.r !== 8'(er) || o.c !== 1'(ec)) begin fails++; $display("FAIL rand_result op%0d m%0d: got %h/%b want %h/%b", n, m, o.r, o.c, 8'(er), 1'(ec)); end
      tests++; if (o.e !== 1'(ee) || o.err_cnt !== ee) begin fails++; $display("FAIL rand_err op%0d: got %b want %0d", n, o.e, ee); end
      tests++; if (o.hc !== 3'(ehc) || o.bfb !== 4'(er)) begin fails++; $display("FAIL rand_status op%0d: hc %0d bfb %h want %0d %h", n, o.hc, o.bfb, ehc, 4'(er)); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int er, ec, ee, ehc, dcnt;
    run_op(2'd0, 8'hA5, 0, 0, o);
    model_apply(2'd0, 8'hA5, er, ec, ee, ehc);
    @(negedge clock); mode = 2'd1; go = 1'b1;
    @(posedge clock);
    @(negedge clock); go = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2; reset = 1'b1;
    #1;
    tests++; if ({result, b_feedback, carry, done, err, busy, history_count} !== '0) begin fails++; $display("FAIL midop_async_reset: got %h want 0", {result, b_feedback, carry, done, err, busy, history_count}); end
    @(negedge clock); reset = 1'b0; model_clear();
    dcnt = 0;
    repeat (8) begin @(negedge clock); if (done) dcnt++; end
    tests++; if (dcnt !== 0 || result !== 8'h00) begin fails++; $display("FAIL midop_after_release: done %0d result %h want 0 00", dcnt, result); end
    run_op(2'd0, 8'h77, 0, 0, o);
    model_apply(2'd0, 8'h77, er, ec, ee, ehc);
    tests++; if (o.r !== 8'(er) || o.hc !== 3'(ehc)) begin fails++; $display("FAIL midop_recover: got %h hc %0d want %h %0d", o.r, o.hc, 8'(er), ehc); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_capture();
    test_shift_rotate();
    test_history();
    test_sample_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_register.md
Name: alu_result_register

Overview:
- Registered output stage directly downstream of the lab's 4-bit combinational ALU.
- Captures the ALU's 8-bit result on a synchronized, edge-detected "go" strobe, or applies shift/rotate/undo to the held value.
- Drives LEDR/HEX from the register and feeds the low nibble back as the ALU's B operand.
- Keeps a small LIFO history of previous register values so the user can undo.

Parameters:
- WIDTH, 8, register/result width; must equal the ALU output width.
- HIST_DEPTH, 4, number of history entries; must be at least 1.

Ports:
- clock  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  asynchronous, active-high reset.
- go  input  1  asynchronous level, active-high (top inverts KEY); a rising edge requests one operation.
- mode  input  2  operation select: 00 capture, 01 shift left, 10 rotate right, 11 undo.
- alu_result  input  WIDTH  combinational ALU output.
- result  output  WIDTH  held register value.
- b_feedback  output  4  result[3:0]; combinational from the register, to ALU B.
- carry  output  1  bit shifted out by the last shift-left.
- done  output  1  one-cycle pulse when an operation completes.
- err  output  1  one-cycle pulse, coincident with done, for undo with an empty history.
- busy  output  1  high when state is not IDLE.
- history_count  output  3  number of valid history entries, 0..HIST_DEPTH.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - result=0, carry=0, done=0, err=0, busy=0, history_count=0, state=IDLE.
  - Synchronizer flops go_s1, go_s2, go_s3 all reset to 1, so a go held through reset does not trigger; a release and re-press is required.
- Synchronizer and edge detect:
  - go passes through go_s1 -> go_s2 -> go_s3.
  - go_pulse = go_s2 & ~go_s3.
- FSM has three states: IDLE, EXEC, DONE.
  - IDLE: on go_pulse, latch mode and alu_result into op registers and go to EXEC. Otherwise stay.
  - EXEC: perform the latched op, go to DONE.
  - DONE: done=1 (and err if applicable) for this single cycle, then go to IDLE.
  - go_pulse arriving in EXEC or DONE is ignored and not queued.
- Latency:
  - go first sampled high at edge k.
  - go_pulse is high in the cycle after edge k+1.
  - EXEC is entered at edge k+2.
  - result and carry update at edge k+3; done is high during the following cycle.
  - alu_result is sampled at edge k+2, so later changes to A/B/function do not affect the op.
- Ops, where R = the current result:
  - 00 capture: push R, result=latched alu_result, carry=0.
  - 01 shift left: push R, result={R[WIDTH-2:0],0}, carry=R[WIDTH-1].
  - 10 rotate right: push R, result={R[0],R[WIDTH-1:1]}, carry unchanged.
  - 11 undo, history non-empty: pop top into result, carry=0, history_count decrements.
  - 11 undo, history empty: result unchanged, err pulses with done.
- History LIFO:
  - A push with history_count<HIST_DEPTH increments the count.
  - A push when full discards the oldest entry; the count stays at HIST_DEPTH.
  - Each op is a single push or a single pop; push and pop never occur in the same cycle.
- Status outputs:
  - busy is 1 in EXEC and DONE.
  - b_feedback always tracks result[3:0] with zero latency.

Optional Feature:
- Macro: ALU_REG_HIST_EN.
- Defined: history LIFO and undo behave as above.
- Undefined:
  - No history storage; history_count is tied to 0.
  - mode 11 clears result and carry to 0 (a clear op); err is never asserted.

Test Plan:
- Reset with go=1 held, then release reset; go stays high -> no done and result=0. Drop go, raise go -> done fires once.
- alu_result=8'h0A, mode=00, go pulse -> result=8'h0A at edge k+3, done high one cycle, b_feedback=4'hA, history_count=1.
- result=8'h81, mode=01 -> result=8'h02, carry=1. Then mode=10 -> result=8'h01, carry=1, history_count incremented twice.
- Five captures (values 1,2,3,4,5) -> history_count=4. Four undos -> result 4,3,2,1 in turn. Fifth undo -> result stays 1, err pulses with done.
- Toggle alu_result on every cycle after edge k+2 -> result equals the value present at edge k+2. Raise go again during EXEC -> ignored, exactly one done.
- Assert reset during EXEC -> all outputs zero immediately (asynchronously); no done pulse after reset is released.
